// File: rtl/muldiv_sequencer.sv
// Iterative signed mult/madd/msub/div engine for the HI/LO path.
// Does one shift-add or restoring shift-subtract step per cycle, then one sign-fix cycle.
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [WIDTH-1:0] hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi_res,
    output logic [WIDTH-1:0] lo_res
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_MADD = 2'b01;
    localparam logic [1:0] OP_MSUB = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   mag_q, mag_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] base_q, base_d;
    logic               neg_q, neg_d;
    logic               rsneg_q, rsneg_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH-1:0]   rs_mag, rt_mag, quo_fix, rem_fix;
    logic [WIDTH:0]     add_sum, shifted, diff;
    logic [2*WIDTH-1:0] prod_fix, fix_val;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            mag_q   <= '0;
            acc_q   <= '0;
            base_q  <= '0;
            neg_q   <= 1'b0;
            rsneg_q <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            mag_q   <= mag_d;
            acc_q   <= acc_d;
            base_q  <= base_d;
            neg_q   <= neg_d;
            rsneg_q <= rsneg_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // mag_q holds |rs| as multiplicand or |rt| as divisor; acc_q is product or {rem, quo}.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        mag_d   = mag_q;
        acc_d   = acc_q;
        base_d  = base_q;
        neg_d   = neg_q;
        rsneg_d = rsneg_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        rs_mag  = rs_val[WIDTH-1] ? -rs_val : rs_val;
        rt_mag  = rt_val[WIDTH-1] ? -rt_val : rt_val;
        add_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mag_q : {WIDTH{1'b0}})};
        shifted = acc_q[2*WIDTH-1:WIDTH-1];
        diff    = shifted - {1'b0, mag_q};

        prod_fix = neg_q ? -acc_q : acc_q;
        quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = rsneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MADD: fix_val = base_q + prod_fix;
            OP_MSUB: fix_val = base_q - prod_fix;
            OP_DIV:  fix_val = {rem_fix, quo_fix};
            default: fix_val = prod_fix;
        endcase

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op;
                    neg_d   = rs_val[WIDTH-1] ^ rt_val[WIDTH-1];
                    rsneg_d = rs_val[WIDTH-1];
                    base_d  = {hi_in, lo_in};
                    cnt_d   = '0;
                    if (op == OP_DIV) begin
                        mag_d = rt_mag;
                        acc_d = {{WIDTH{1'b0}}, rs_mag};
                    end else begin
                        mag_d = rs_mag;
                        acc_d = {{WIDTH{1'b0}}, rt_mag};
                    end
                    if (op == OP_DIV && rt_val == '0) begin
                        state_d = DONE;
                        dz_d    = 1'b1;
                        hi_d    = hi_in;
                        lo_d    = lo_in;
                    end else begin
                        state_d = CALC;
                        dz_d    = 1'b0;
                    end
                end
            end
            CALC: begin
                if (op_q == OP_DIV) begin
                    if (!diff[WIDTH])
                        acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                    else
                        acc_d = {shifted[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = {add_sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                    cnt_d   = '0;
                end
            end
            FIX: begin
                hi_d    = fix_val[2*WIDTH-1:WIDTH];
                lo_d    = fix_val[WIDTH-1:0];
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Flush abandons the operation without touching the visible results.
        if (flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            dz_d    = dz_q;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign div_zero = (state_q == DONE) && dz_q;
    assign hi_res   = hi_q;
    assign lo_res   = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed plan cases, corners and random ops
// compared against a plain-arithmetic signed reference model.
module tb_muldiv_sequencer;
    localparam int WIDTH = 32;
    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_MADD = 2'b01;
    localparam logic [1:0] OP_MSUB = 2'b10;
    localparam logic [1:0] OP_DIV  = 2'b11;

    logic             clk;
    logic             rstN;
    logic             startIn;
    logic [1:0]       opIn;
    logic [WIDTH-1:0] rsVal, rtVal, hiIn, loIn;
    logic             flushIn;
    logic             busyOut, doneOut, divZeroOut;
    logic [WIDTH-1:0] hiRes, loRes;

    int assertCount = 0;
    int failCount   = 0;
    int doneCount   = 0;
    logic [63:0] lastExp = '0;

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rstN),
        .start    (startIn),
        .op       (opIn),
        .rs_val   (rsVal),
        .rt_val   (rtVal),
        .hi_in    (hiIn),
        .lo_in    (loIn),
        .flush    (flushIn),
        .busy     (busyOut),
        .done     (doneOut),
        .div_zero (divZeroOut),
        .hi_res   (hiRes),
        .lo_res   (loRes)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (doneOut === 1'b1) doneCount++;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Signed reference model built from the arithmetic definitions of each op.
    task automatic refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] h, input logic [31:0] l,
                            output logic [63:0] res, output logic dz);
        longint sa, sb, p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = sa * sb;
        dz = 1'b0;
        case (o)
            OP_MULT: res = p;
            OP_MADD: res = {h, l} + p;
            OP_MSUB: res = {h, l} - p;
            default: begin
                if (sb == 0) begin
                    res = {h, l};
                    dz  = 1'b1;
                end else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
        endcase
    endtask

    // Drives one launch; returns at the negedge just after the accepting edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        opIn = o; rsVal = a; rtVal = b; hiIn = h; loIn = l;
        startIn = 1'b1;
        @(negedge clk);
        startIn = 1'b0;
        opIn = 2'($urandom_range(0, 3));
        rsVal = $urandom; rtVal = $urandom; hiIn = $urandom; loIn = $urandom;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 1;
        while (doneOut !== 1'b1 && cycles < 200) begin
            @(negedge clk);
            cycles++;
        end
        if (doneOut !== 1'b1) checkOutput("doneTimeout", 64'd0, 64'd1);
    endtask

    task automatic runAndCheck(input string tag, input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] h, input logic [31:0] l);
        logic [63:0] expRes;
        logic        expDz;
        int          cyc;
        refModel(o, a, b, h, l, expRes, expDz);
        applyStimulus(o, a, b, h, l);
        checkOutput({tag, "_busy"}, {63'd0, busyOut}, 64'd1);
        waitDone(cyc);
        checkOutput({tag, "_latency"}, 64'(cyc), expDz ? 64'd1 : 64'd34);
        checkOutput({tag, "_result"}, {hiRes, loRes}, expRes);
        checkOutput({tag, "_divZero"}, {63'd0, divZeroOut}, {63'd0, expDz});
        lastExp = expRes;
        startIn = 1'b1;
        opIn = OP_MULT; rsVal = 32'd9; rtVal = 32'd9;
        @(negedge clk);
        startIn = 1'b0;
        checkOutput({tag, "_idleAfter"}, {62'd0, busyOut, doneOut}, 64'd0);
        checkOutput({tag, "_resultHeld"}, {hiRes, loRes}, expRes);
    endtask

    initial begin
        int d0, cyc;
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        rstN = 1'b0; startIn = 1'b0; flushIn = 1'b0; opIn = '0;
        rsVal = '0; rtVal = '0; hiIn = '0; loIn = '0;
        repeat (3) @(negedge clk);
        checkOutput("resetFlags", {61'd0, busyOut, doneOut, divZeroOut}, 64'd0);
        checkOutput("resetResult", {hiRes, loRes}, 64'd0);
        rstN = 1'b1;
        @(negedge clk);
        $display("[TB] directed plan cases");

        runAndCheck("mult7xm3", OP_MULT, 32'd7, 32'hFFFFFFFD, 32'd0, 32'd0);
        checkOutput("mult7xm3_const", {hiRes, loRes}, 64'hFFFFFFFF_FFFFFFEB);
        runAndCheck("divm7by2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'd0, 32'd0);
        checkOutput("divm7by2_const", {hiRes, loRes}, 64'hFFFFFFFF_FFFFFFFD);
        runAndCheck("madd", OP_MADD, 32'd1, 32'd1, 32'd0, 32'hFFFFFFFF);
        checkOutput("madd_const", {hiRes, loRes}, 64'h00000001_00000000);
        runAndCheck("msub", OP_MSUB, 32'd2, 32'd3, 32'd0, 32'd0);
        checkOutput("msub_const", {hiRes, loRes}, 64'hFFFFFFFF_FFFFFFFA);
        runAndCheck("divZero", OP_DIV, 32'd5, 32'd0, 32'h11, 32'h22);
        checkOutput("divZero_const", {hiRes, loRes}, 64'h00000011_00000022);
        runAndCheck("divMinByM1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd0);
        checkOutput("divMinByM1_const", {hiRes, loRes}, 64'h00000000_80000000);
        runAndCheck("multMinMin", OP_MULT, 32'h80000000, 32'h80000000, 32'd0, 32'd0);
        checkOutput("multMinMin_const", {hiRes, loRes}, 64'h40000000_00000000);

        $display("[TB] second start while busy");
        d0 = doneCount;
        applyStimulus(OP_MULT, 32'd3, 32'd4, 32'd0, 32'd0);
        repeat (9) @(negedge clk);
        opIn = OP_MULT; rsVal = 32'd5; rtVal = 32'd5; startIn = 1'b1;
        @(negedge clk);
        startIn = 1'b0;
        waitDone(cyc);
        repeat (40) @(negedge clk);
        checkOutput("ignoredStart_result", {hiRes, loRes}, 64'd12);
        checkOutput("ignoredStart_doneCount", 64'(doneCount - d0), 64'd1);
        lastExp = 64'd12;

        $display("[TB] flush mid-divide");
        applyStimulus(OP_DIV, 32'd100, 32'd7, 32'd0, 32'd0);
        repeat (14) @(negedge clk);
        flushIn = 1'b1;
        @(negedge clk);
        flushIn = 1'b0;
        checkOutput("flush_busy", {63'd0, busyOut}, 64'd0);
        d0 = doneCount;
        repeat (40) @(negedge clk);
        checkOutput("flush_noDone", 64'(doneCount - d0), 64'd0);
        checkOutput("flush_resultHeld", {hiRes, loRes}, lastExp);

        $display("[TB] flush with start in idle");
        d0 = doneCount;
        opIn = OP_DIV; rsVal = 32'd8; rtVal = 32'd0; hiIn = 32'h5; loIn = 32'h6;
        startIn = 1'b1; flushIn = 1'b1;
        @(negedge clk);
        startIn = 1'b0; flushIn = 1'b0;
        checkOutput("flushStart_busy", {63'd0, busyOut}, 64'd0);
        repeat (3) @(negedge clk);
        checkOutput("flushStart_noDone", 64'(doneCount - d0), 64'd0);
        checkOutput("flushStart_resultHeld", {hiRes, loRes}, lastExp);

        $display("[TB] reset mid-divide");
        applyStimulus(OP_DIV, 32'd100, 32'd7, 32'd0, 32'd0);
        repeat (14) @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        checkOutput("midReset_flags", {61'd0, busyOut, doneOut, divZeroOut}, 64'd0);
        checkOutput("midReset_result", {hiRes, loRes}, 64'd0);
        runAndCheck("mult2x2", OP_MULT, 32'd2, 32'd2, 32'd0, 32'd0);
        checkOutput("mult2x2_lo", {32'd0, loRes}, 64'd4);

        $display("[TB] random operations");
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'hFFFFFFFF;
                2:       rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            runAndCheck("random", rop, ra, rb, $urandom, $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multi-cycle multiply/divide engine and its sequencer for the HI/LO path of the microprogrammed MIPS core.
- Executes mult, madd, msub and div over 32 iterations and returns a 64-bit {HI,LO} result through a start/busy/done handshake.
- The control unit holds its microprogram state while busy is high, then writes HI/LO on done.

Parameters:
- WIDTH, 32, operand width; the iteration count equals WIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  launch request; sampled only in IDLE.
- op  in  2  operation: 00 mult, 01 madd, 10 msub, 11 div (all signed).
- rs_val  in  WIDTH  multiplicand / dividend.
- rt_val  in  WIDTH  multiplier / divisor.
- hi_in  in  WIDTH  current HI, used as accumulator for madd/msub.
- lo_in  in  WIDTH  current LO, used as accumulator for madd/msub.
- flush  in  1  cancels the in-flight operation (exception path).
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle result strobe.
- div_zero  out  1  asserted together with done when a div has divisor 0.
- hi_res  out  WIDTH  result HI; remainder for div.
- lo_res  out  WIDTH  result LO; quotient for div.

Behaviour:
- Reset (rst_n low at a clock edge): state IDLE; busy, done, div_zero = 0; hi_res, lo_res = 0; iteration counter = 0; internal operand registers = 0.
- States:
  - IDLE -> CALC when start=1. rs_val, rt_val, hi_in, lo_in and op are latched at that edge (E0). Magnitudes of the operands are stored, and the result sign is recorded.
  - IDLE -> DONE instead of CALC when op=div and rt_val=0.
  - CALC: one iteration per edge, E1..E32.
    - mult/madd/msub: shift-add on a 64-bit product register.
    - div: restoring shift-subtract on a 64-bit {remainder, quotient} register.
    - The counter runs 0..WIDTH-1. At count WIDTH-1 the next state is FIX.
  - FIX (edge E33), sign correction:
    - Product is negated if operand signs differ.
    - Quotient is negated if operand signs differ; remainder takes the sign of the dividend.
    - madd: {hi_in,lo_in} + product. msub: {hi_in,lo_in} - product. Both are 64-bit, with wrap on overflow and no flag.
    - Result is registered into hi_res/lo_res. Next state is DONE.
  - DONE: done=1 for exactly one cycle, then IDLE on the next edge.
- Latency: start accepted at E0 -> done high in the cycle after E33, i.e. 34 cycles. Divide-by-zero: done high in the cycle after E0.
- Divide by zero: div_zero=1 with done; hi_res=hi_in, lo_res=lo_in as latched at E0.
- hi_res/lo_res hold their value until the next FIX or divide-by-zero DONE.
- busy is high from the edge after E0 through the DONE cycle inclusive. start is ignored while busy, including during the DONE cycle, and the latched operands do not change.
- Operand changes after E0 have no effect.
- flush=1 in any state: next state IDLE, counter cleared, no done; hi_res/lo_res unchanged.
- flush and start together in IDLE: flush wins and nothing launches.
- rst_n low mid-operation: same as reset, and all outputs are cleared.
- Corner cases:
  - div 0x80000000 / 0xFFFFFFFF: lo_res=0x80000000, hi_res=0, no flag.
  - mult 0x80000000 * 0x80000000: {hi,lo}=0x40000000_00000000.

Test Plan:
- mult rs=7, rt=0xFFFFFFFD (-3) -> done exactly 34 cycles after start; hi_res=0xFFFFFFFF, lo_res=0xFFFFFFEB; busy low the cycle after done.
- div rs=0xFFFFFFF9 (-7), rt=2 -> lo_res=0xFFFFFFFD (-3), hi_res=0xFFFFFFFF (-1); div_zero=0.
- madd hi_in=0, lo_in=0xFFFFFFFF, rs=1, rt=1 -> hi_res=1, lo_res=0. msub hi_in=0, lo_in=0, rs=2, rt=3 -> hi_res=0xFFFFFFFF, lo_res=0xFFFFFFFA.
- div rs=5, rt=0, hi_in=0x11, lo_in=0x22 -> done and div_zero both high one cycle after start; hi_res=0x11, lo_res=0x22.
- mult 3*4 started, second start (mult 5*5) pulsed at cycle 10 -> ignored; result lo_res=12, only one done pulse.
- div 100/7 started; flush at cycle 15 -> IDLE next cycle, no done, results unchanged. Repeat with rst_n=0 at cycle 15 -> all outputs 0 next cycle; a fresh mult 2*2 then yields lo_res=4.
